// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register: skid FSM states,
// control-vector bit positions and the stall counter width.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    localparam int CTRL_MEM_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_WB_ALU     = 2;
    localparam int CTRL_WB_MEM     = 3;
    localparam int CTRL_RF_WE      = 4;
    localparam int CTRL_CIN_SEL    = 5;
    localparam int CTRL_ALU_OP_LSB = 6;
    localparam int CTRL_ALU_OP_W   = 4;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_slot.sv
// One holding slot: valid bit plus ctrl/data/instr registers.
// Clear wins over load so a squashed cycle never captures a new entry.
module pipe_slot #(
    parameter int DATA_W  = 64,
    parameter int CTRL_W  = 10,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [DATA_W-1:0]  d_data,
    input  logic [CTRL_W-1:0]  d_ctrl,
    input  logic [INSTR_W-1:0] d_instr,
    output logic               v,
    output logic [DATA_W-1:0]  data,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [INSTR_W-1:0] instr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            v     <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
            instr <= '0;
        end else if (clear) begin
            // Payload and instruction are left stale; only ctrl must read as zero.
            v    <= 1'b0;
            ctrl <= '0;
        end else if (load) begin
            v     <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
            instr <= d_instr;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush and a
// saturating stall counter. Define PIPE_SKID_EN for the registered-ready skid build.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int CTRL_W  = 10,
    parameter int INSTR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [INSTR_W-1:0]     in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic               accept;
    logic               consume;
    logic               m_v;
    logic               m_load;
    logic               m_clear;
    logic [DATA_W-1:0]  m_d_data;
    logic [CTRL_W-1:0]  m_d_ctrl;
    logic [INSTR_W-1:0] m_d_instr;

    assign accept    = in_valid && in_ready;
    assign consume   = m_v && out_ready;
    assign out_valid = m_v;

`ifdef PIPE_SKID_EN
    pipe_state_t        state_reg;
    pipe_state_t        state_next;
    logic               s_v;
    logic               s_load;
    logic               s_clear;
    logic               m_from_s;
    logic [DATA_W-1:0]  s_data;
    logic [CTRL_W-1:0]  s_ctrl;
    logic [INSTR_W-1:0] s_instr;

    // Ready depends only on the skid valid flop, cutting the out_ready -> in_ready path.
    assign in_ready = !s_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY:   if (accept) state_next = FULL;
                FULL: begin
                    if (accept && !consume)      state_next = SKID;
                    else if (!accept && consume) state_next = EMPTY;
                end
                SKID:    if (consume) state_next = FULL;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        m_load   = 1'b0;
        m_clear  = 1'b0;
        s_load   = 1'b0;
        s_clear  = 1'b0;
        m_from_s = 1'b0;
        if (flush) begin
            m_clear = 1'b0 | 1'b1;
            s_clear = 1'b1;
        end else begin
            case (state_reg)
                EMPTY: m_load = accept;
                FULL: begin
                    if (accept && consume) m_load  = 1'b1;
                    else if (accept)       s_load  = 1'b1;
                    else if (consume)      m_clear = 1'b1;
                end
                SKID: begin
                    if (consume) begin
                        m_load   = 1'b1;
                        m_from_s = 1'b1;
                        s_clear  = 1'b1;
                    end
                end
                default: begin
                    m_clear = 1'b1;
                    s_clear = 1'b1;
                end
            endcase
        end
    end

    assign m_d_data  = m_from_s ? s_data  : in_data;
    assign m_d_ctrl  = m_from_s ? s_ctrl  : in_ctrl;
    assign m_d_instr = m_from_s ? s_instr : in_instr;

    pipe_slot #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .INSTR_W (INSTR_W)
    ) u_s_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (s_load),
        .clear   (s_clear),
        .d_data  (in_data),
        .d_ctrl  (in_ctrl),
        .d_instr (in_instr),
        .v       (s_v),
        .data    (s_data),
        .ctrl    (s_ctrl),
        .instr   (s_instr)
    );
`else
    assign in_ready  = out_ready || !m_v;
    assign m_load    = accept;
    assign m_clear   = flush || (consume && !accept);
    assign m_d_data  = in_data;
    assign m_d_ctrl  = in_ctrl;
    assign m_d_instr = in_instr;
`endif

    pipe_slot #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .INSTR_W (INSTR_W)
    ) u_m_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (m_load),
        .clear   (m_clear),
        .d_data  (m_d_data),
        .d_ctrl  (m_d_ctrl),
        .d_instr (m_d_instr),
        .v       (m_v),
        .data    (out_data),
        .ctrl    (out_ctrl),
        .instr   (out_instr)
    );

    // Flush deliberately leaves the counter alone so stall history survives squashes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (m_v && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps then random traffic,
// compared against a queue-based model of the stage (honours PIPE_SKID_EN).
module tb_pipe_stage_reg;

    typedef struct {
        logic [63:0] d;
        logic [9:0]  c;
        logic [31:0] i;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_data, out_data;
    logic [9:0]  in_ctrl, out_ctrl;
    logic [31:0] in_instr, out_instr;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    ent_t q[$];
    int   model_cnt = 0;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_instr (out_instr),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [63:0] d, input logic [9:0] c, input logic [31:0] i);
        ent_t e;
        e.d = d; e.c = c; e.i = i;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        return mk({$urandom, $urandom}, 10'($urandom), $urandom);
    endfunction

    // One clock cycle: drive inputs, optionally check outputs, advance the model at the edge.
    task automatic step(input bit r, input bit f, input bit iv, input bit ordy,
                        input ent_t e, input bit do_chk, input string tag);
        bit exp_rdy, acc, cons;
        rst = r; flush = f; in_valid = iv; out_ready = ordy;
        in_data = e.d; in_ctrl = e.c; in_instr = e.i;
        #1;
        exp_rdy = SKID ? (q.size() < 2) : (ordy || q.size() == 0);
        if (do_chk) begin
            chk({tag, ".in_ready"},  64'(in_ready),  64'(exp_rdy));
            chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
            chk({tag, ".out_ctrl"},  64'(out_ctrl),  (q.size() > 0) ? 64'(q[0].c) : 64'd0);
            chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(model_cnt));
            if (q.size() > 0) begin
                chk({tag, ".out_data"},  out_data,         q[0].d);
                chk({tag, ".out_instr"}, 64'(out_instr),   64'(q[0].i));
            end
        end
        acc  = iv && exp_rdy;
        cons = (q.size() > 0) && ordy;
        @(posedge clk);
        if (r) begin
            q.delete();
            model_cnt = 0;
        end else begin
            if (q.size() > 0 && !ordy && model_cnt < 65535) model_cnt++;
            if (f) begin
                q.delete();
            end else begin
                if (cons) void'(q.pop_front());
                if (acc)  q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    ent_t z;
    ent_t ea, eb;

    initial begin
        z = mk(64'd0, 10'd0, 32'd0);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0; in_instr = '0;
        @(negedge clk);

        // Reset held two cycles with in_valid high.
        step(1, 0, 1, 0, rnd_ent(), 0, "rst0");
        step(1, 0, 1, 0, rnd_ent(), 1, "rst1");
        rst = 1'b0; in_valid = 1'b0; #1;
        chk("reset.out_data",  out_data,        64'd0);
        chk("reset.out_instr", 64'(out_instr),  64'd0);
        chk("reset.in_ready",  64'(in_ready),   64'd1);
        @(negedge clk);

        // Streaming 1..8 with out_ready high.
        for (int k = 1; k <= 8; k++)
            step(0, 0, 1, 1, mk(64'(k), 10'(k), 32'(100 + k)), 1, $sformatf("stream%0d", k));
        step(0, 0, 0, 1, z, 1, "stream_drain");
        step(0, 0, 0, 1, z, 1, "stream_idle");

        // Backpressure: offer A then B while downstream stalls, then release.
        ea = mk(64'hAAAA_0000_AAAA_0001, 10'h0A1, 32'hA0A0_A0A0);
        eb = mk(64'hBBBB_0000_BBBB_0002, 10'h0B2, 32'hB0B0_B0B0);
        step(0, 0, 1, 0, ea, 1, "bp_a");
        step(0, 0, 1, 0, eb, 1, "bp_b");
        step(0, 0, 0, 0, z,  1, "bp_hold");
        step(0, 0, 0, 1, z,  1, "bp_out1");
        step(0, 0, 0, 1, z,  1, "bp_out2");
        step(0, 0, 0, 1, z,  1, "bp_out3");

        // Flush: hold an all-ones ctrl entry, flush while offering C.
        step(0, 0, 1, 0, mk(64'h1234, 10'h3FF, 32'h5678), 1, "fl_load");
        step(0, 1, 1, 0, mk(64'hC0C0, 10'h0CC, 32'hCCCC), 1, "fl_pulse");
        step(0, 0, 0, 1, z, 1, "fl_after");
        step(0, 1, 1, 1, mk(64'hC1C1, 10'h0C1, 32'hC1C1), 1, "fl_accept");
        step(0, 0, 0, 1, z, 1, "fl_after2");

        // Bubble: consume D with nothing behind it.
        step(0, 0, 1, 1, mk(64'hD00D, 10'h155, 32'hDDDD), 1, "bub_load");
        step(0, 0, 0, 1, z, 1, "bub_consume");
        step(0, 0, 0, 1, z, 1, "bub_empty");

        // Random traffic with occasional flush and reset.
        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                 1'($urandom), ($urandom_range(0, 3) != 0), rnd_ent(), 1, $sformatf("rnd%0d", k));

        // Saturating stall counter.
        step(1, 0, 0, 0, z, 0, "cnt_rst");
        step(0, 0, 1, 0, mk(64'hE, 10'h00E, 32'hE), 1, "cnt_load");
        for (int k = 0; k < 70000; k++)
            step(0, 0, 0, 0, z, 0, "cnt_run");
        step(0, 0, 0, 0, z, 1, "cnt_sat");
        chk("cnt_sat.value", 64'(stall_cnt), 64'hFFFF);
        step(0, 0, 0, 0, z, 1, "cnt_hold");
        step(0, 1, 0, 0, z, 1, "cnt_flush");
        step(0, 0, 0, 0, z, 1, "cnt_post_flush");
        chk("cnt_post_flush.value", 64'(stall_cnt), 64'hFFFF);
        step(1, 0, 0, 0, z, 0, "cnt_clr");
        step(0, 0, 0, 0, z, 1, "cnt_cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
